fpu_addsub_core: RTL and testbench

Iterative IEEE-754 single-precision adder/subtractor that sits directly downstream of the AXI-Lite slave register file of the FPU IP. The register file presents operands, opcode and a one-cycle start pulse. This block computes the rounded result over a fixed four-cycle sequence and returns result, status flags and a one-cycle done pulse. The register file latches them for software readback.

---
 rtl/fpu_addsub_core.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_fpu_addsub_core.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_core.sv
// fpu_addsub_core
// Iterative FP32 adder/subtractor. It runs a fixed five-state sequence
// (IDLE, ALIGN, ADD, NORM, ROUND), so every operation takes the same time.
// Denormal operands are flushed to zero on input, and tiny results are
// flushed to zero on output. Results use round-to-nearest-even.
//
// Ports:
//   ACLK    - clock; all state changes on the rising edge
//   ARESET  - asynchronous active-high reset
//   start   - one-cycle request; sampled only while idle
//   op      - 0 = A+B, 1 = A-B; sampled with start
//   op_a    - operand A (FP32); sampled with start
//   op_b    - operand B (FP32); sampled with start
//   busy    - high while an operation is in flight
//   done    - one-cycle pulse; result and flags are valid from this cycle
//   result  - rounded FP32 result; held until the next done
//   flags   - {invalid, overflow, underflow, inexact}; held with result
module fpu_addsub_core (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ALIGN = 3'd1;
    localparam logic [2:0] ST_ADD   = 3'd2;
    localparam logic [2:0] ST_NORM  = 3'd3;
    localparam logic [2:0] ST_ROUND = 3'd4;

    logic [2:0]  state_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;              // sign of B already reflects op
    logic        sign_big_reg;
    logic        eff_sub_reg;
    logic        zero_sign_reg;
    logic        bypass_reg;
    logic [31:0] bypass_result_reg;
    logic [3:0]  bypass_flags_reg;
    logic [9:0]  exp_big_reg;        // signed biased exponent
    logic [25:0] sig_big_reg;        // {hidden, 23 frac, guard, round}
    logic [25:0] sig_small_reg;      // aligned smaller operand
    logic        sticky_reg;
    logic [27:0] sum_reg;            // {carry, 24 sig, guard, round, sticky}
    logic [26:0] norm_sig_reg;
    logic [9:0]  norm_exp_reg;
    logic        norm_zero_reg;
    logic [31:0] result_reg;
    logic [3:0]  flags_reg;
    logic        done_reg;

    // Operand unpack. Index 0 is A and index 1 is B. A zero exponent field
    // means zero or denormal, and both become a zero significand.
    logic [31:0] opnd   [2];
    logic        u_sign [2];
    logic [7:0]  u_exp  [2];
    logic [23:0] u_sig  [2];
    logic        u_zero [2];
    logic        u_inf  [2];
    logic        u_nan  [2];
    logic        u_snan [2];

    assign opnd[0] = a_reg;
    assign opnd[1] = b_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign u_sign[gi] = opnd[gi][31];
            assign u_exp[gi]  = opnd[gi][30:23];
            assign u_zero[gi] = (opnd[gi][30:23] == 8'd0);
            assign u_sig[gi]  = u_zero[gi] ? 24'd0 : {1'b1, opnd[gi][22:0]};
            assign u_inf[gi]  = (&opnd[gi][30:23]) && (opnd[gi][22:0] == 23'd0);
            assign u_nan[gi]  = (&opnd[gi][30:23]) && (opnd[gi][22:0] != 23'd0);
            assign u_snan[gi] = u_nan[gi] && !opnd[gi][22];
        end
    endgenerate

    // Alignment. Swap the operands so the larger magnitude is the big one,
    // then right-shift the small one. Shift amounts of 26 or more are clamped
    // to 26. At 26 the whole significand lands below the round bit and only
    // contributes to sticky.
    logic        a_ge_b_c;
    logic [7:0]  exp_diff_c;
    logic [4:0]  shamt_c;
    logic [23:0] small_sig_c;
    logic [49:0] shifted_c;

    assign a_ge_b_c    = {u_exp[0], u_sig[0]} >= {u_exp[1], u_sig[1]};
    assign exp_diff_c  = a_ge_b_c ? (u_exp[0] - u_exp[1]) : (u_exp[1] - u_exp[0]);
    assign shamt_c     = (exp_diff_c >= 8'd26) ? 5'd26 : exp_diff_c[4:0];
    assign small_sig_c = a_ge_b_c ? u_sig[1] : u_sig[0];

    // Logarithmic barrel shifter.
    always_comb begin
        shifted_c = {small_sig_c, 26'd0};
        for (int i = 0; i < 5; i++) begin
            if (shamt_c[i]) begin
                shifted_c = shifted_c >> (1 << i);
            end
        end
    end

    // Special-case classification. These results skip the datapath but are
    // still retired through ROUND, so the latency does not change.
    logic        bypass_c;
    logic [31:0] bypass_result_c;
    logic [3:0]  bypass_flags_c;

    always_comb begin
        bypass_c        = 1'b1;
        bypass_result_c = 32'h7FC0_0000;
        bypass_flags_c  = 4'b0000;
        if (u_nan[0] || u_nan[1]) begin
            bypass_flags_c = {u_snan[0] | u_snan[1], 3'b000};
        end else if (u_inf[0] && u_inf[1] && (u_sign[0] != u_sign[1])) begin
            bypass_flags_c = 4'b1000;
        end else if (u_inf[0]) begin
            bypass_result_c = {u_sign[0], 8'hFF, 23'd0};
        end else if (u_inf[1]) begin
            bypass_result_c = {u_sign[1], 8'hFF, 23'd0};
        end else begin
            bypass_c        = 1'b0;
            bypass_result_c = 32'd0;
        end
    end

    // Add or subtract. Sticky sits in the LSB so that a subtraction borrows
    // correctly through it.
    logic [27:0] big_ext_c;
    logic [27:0] small_ext_c;
    logic [27:0] sum_c;

    assign big_ext_c   = {1'b0, sig_big_reg, 1'b0};
    assign small_ext_c = {1'b0, sig_small_reg, sticky_reg};
    assign sum_c       = eff_sub_reg ? (big_ext_c - small_ext_c) : (big_ext_c + small_ext_c);

    // Normalise. On a carry-out, shift right by one and fold the lost bit
    // into sticky. Otherwise shift left by the leading-zero count.
    logic [4:0]  lzc_c;
    logic        lz_found_c;
    logic [26:0] norm_sig_c;
    logic [9:0]  norm_exp_c;

    always_comb begin
        lzc_c      = 5'd0;
        lz_found_c = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!lz_found_c) begin
                if (sum_reg[i]) begin
                    lz_found_c = 1'b1;
                end else begin
                    lzc_c = lzc_c + 5'd1;
                end
            end
        end
        norm_sig_c = sum_reg[26:0] << lzc_c;
        norm_exp_c = exp_big_reg - {5'd0, lzc_c};
        if (sum_reg[27]) begin
            norm_sig_c = {sum_reg[27:2], sum_reg[1] | sum_reg[0]};
            norm_exp_c = exp_big_reg + 10'd1;
        end
    end

    // Round to nearest even, then pack the result with the final checks.
    logic        round_up_c;
    logic        inexact_c;
    logic [24:0] mant_rnd_c;
    logic [23:0] mant_final_c;
    logic [9:0]  exp_final_c;
    logic [31:0] result_c;
    logic [3:0]  flags_c;

    assign inexact_c  = |norm_sig_reg[2:0];
    assign round_up_c = norm_sig_reg[2] & (norm_sig_reg[1] | norm_sig_reg[0] | norm_sig_reg[3]);
    assign mant_rnd_c = {1'b0, norm_sig_reg[26:3]} + {24'd0, round_up_c};

    always_comb begin
        mant_final_c = mant_rnd_c[23:0];
        exp_final_c  = norm_exp_reg;
        if (mant_rnd_c[24]) begin
            mant_final_c = mant_rnd_c[24:1];
            exp_final_c  = norm_exp_reg + 10'd1;
        end
        if (bypass_reg) begin
            result_c = bypass_result_reg;
            flags_c  = bypass_flags_reg;
        end else if (norm_zero_reg) begin
            result_c = {zero_sign_reg, 31'd0};
            flags_c  = 4'b0000;
        end else if ($signed(norm_exp_reg) <= 10'sd0) begin
            result_c = {sign_big_reg, 31'd0};
            flags_c  = 4'b0011;
        end else if ($signed(exp_final_c) >= 10'sd255) begin
            result_c = {sign_big_reg, 8'hFF, 23'd0};
            flags_c  = 4'b0101;
        end else begin
            result_c = {sign_big_reg, exp_final_c[7:0], mant_final_c[22:0]};
            flags_c  = {3'b000, inexact_c};
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_reg         <= ST_IDLE;
            a_reg             <= 32'd0;
            b_reg             <= 32'd0;
            sign_big_reg      <= 1'b0;
            eff_sub_reg       <= 1'b0;
            zero_sign_reg     <= 1'b0;
            bypass_reg        <= 1'b0;
            bypass_result_reg <= 32'd0;
            bypass_flags_reg  <= 4'd0;
            exp_big_reg       <= 10'd0;
            sig_big_reg       <= 26'd0;
            sig_small_reg     <= 26'd0;
            sticky_reg        <= 1'b0;
            sum_reg           <= 28'd0;
            norm_sig_reg      <= 27'd0;
            norm_exp_reg      <= 10'd0;
            norm_zero_reg     <= 1'b0;
            result_reg        <= 32'd0;
            flags_reg         <= 4'd0;
            done_reg          <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_reg     <= op_a;
                        b_reg     <= {op_b[31] ^ op, op_b[30:0]};
                        state_reg <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    sign_big_reg      <= a_ge_b_c ? u_sign[0] : u_sign[1];
                    eff_sub_reg       <= u_sign[0] ^ u_sign[1];
                    zero_sign_reg     <= u_zero[0] & u_zero[1] & u_sign[0] & u_sign[1];
                    exp_big_reg       <= {2'b00, a_ge_b_c ? u_exp[0] : u_exp[1]};
                    sig_big_reg       <= {a_ge_b_c ? u_sig[0] : u_sig[1], 2'b00};
                    sig_small_reg     <= shifted_c[49:24];
                    sticky_reg        <= |shifted_c[23:0];
                    bypass_reg        <= bypass_c;
                    bypass_result_reg <= bypass_result_c;
                    bypass_flags_reg  <= bypass_flags_c;
                    state_reg         <= ST_ADD;
                end
                ST_ADD: begin
                    sum_reg   <= sum_c;
                    state_reg <= ST_NORM;
                end
                ST_NORM: begin
                    norm_sig_reg  <= norm_sig_c;
                    norm_exp_reg  <= norm_exp_c;
                    norm_zero_reg <= (sum_reg == 28'd0);
                    state_reg     <= ST_ROUND;
                end
                ST_ROUND: begin
                    result_reg <= result_c;
                    flags_reg  <= flags_c;
                    done_reg   <= 1'b1;
                    state_reg  <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (state_reg != ST_IDLE);
    assign done   = done_reg;
    assign result = result_reg;
    assign flags  = flags_reg;

endmodule

// File: tb/tb_fpu_addsub_core.sv
// Testbench for fpu_addsub_core. A table of vectors is driven through a
// scoreboard, followed by hand-written handshake and reset sequences.
module tb_fpu_addsub_core;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  flags;

    fpu_addsub_core dut (
        .ACLK   (clk),
        .ARESET (rst),
        .start  (start),
        .op     (op),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          due;
        int          tag;
    } sb_entry_t;

    vec_t      vecs [$];
    sb_entry_t sb   [$];
    int        cyc;
    int        checks;
    int        passes;
    int        dones_seen;

    task automatic check32(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v) begin
            passes++;
        end else begin
            $display("FAIL %s[%0d]: got %08h, expected %08h", name, tag, act, exp_v);
        end
    endtask

    // Advance one cycle and sample at the falling edge. Checks busy and any
    // done pulse against the scoreboard.
    task automatic tick();
        sb_entry_t e;
        logic      exp_busy;
        @(negedge clk);
        cyc++;
        exp_busy = (sb.size() != 0) && (cyc < sb[0].due);
        check32("busy", cyc, {31'd0, busy}, {31'd0, exp_busy});
        if (done === 1'b1) begin
            dones_seen++;
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done[%0d]: got done with result %08h, expected no done", cyc, result);
            end else begin
                e = sb.pop_front();
                check32("result", e.tag, result, e.res);
                check32("flags", e.tag, {28'd0, flags}, {28'd0, e.flg});
                check32("latency", e.tag, cyc, e.due);
                $display("op %0d: result=%08h flags=%04b at cycle %0d", e.tag, result, flags, cyc);
            end
        end else if ((sb.size() != 0) && (cyc == sb[0].due)) begin
            checks++;
            $display("FAIL done_missing[%0d]: got done=0 at cycle %0d, expected done=1", sb[0].tag, cyc);
        end
    endtask

    // Drive one request so it is sampled at the next rising edge, record the
    // expected outcome, then scramble the operand inputs.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic o,
                         input logic [31:0] r, input logic [3:0] f, input int tag);
        sb_entry_t e;
        op_a  = a;
        op_b  = b;
        op    = o;
        start = 1'b1;
        e.res = r;
        e.flg = f;
        e.due = cyc + 5;
        e.tag = tag;
        sb.push_back(e);
        tick();
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        op    = ~o;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; (i < max_cycles) && (sb.size() != 0); i++) begin
            tick();
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL timeout[%0d]: got %0d ops outstanding, expected 0", sb[0].tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int d0;
        cyc        = 0;
        checks     = 0;
        passes     = 0;
        dones_seen = 0;
        rst        = 1'b1;
        start      = 1'b0;
        op         = 1'b0;
        op_a       = 32'd0;
        op_b       = 32'd0;

        vecs.push_back('{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000});
        vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000});
        vecs.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001});
        vecs.push_back('{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001});
        vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101});
        vecs.push_back('{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011});
        vecs.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000});
        vecs.push_back('{32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000});
        vecs.push_back('{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000});
        vecs.push_back('{32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'b0000});
        vecs.push_back('{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000});
        vecs.push_back('{32'hC0400000, 32'h3F800000, 1'b0, 32'hC0000000, 4'b0000});
        vecs.push_back('{32'h3F800000, 32'h00400000, 1'b0, 32'h3F800000, 4'b0000});
        vecs.push_back('{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'b0000});
        vecs.push_back('{32'h3F800000, 32'h30800000, 1'b1, 32'h3F800000, 4'b0001});
        vecs.push_back('{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000});
        vecs.push_back('{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0000});
        vecs.push_back('{32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000});
        vecs.push_back('{32'h3F800000, 32'hFF800001, 1'b0, 32'h7FC00000, 4'b1000});
        vecs.push_back('{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0000});
        vecs.push_back('{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000});

        // Reset state.
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check32("reset_done", 0, {31'd0, done}, 32'd0);
        check32("reset_result", 0, result, 32'h00000000);
        check32("reset_flags", 0, {28'd0, flags}, 32'd0);

        // Table-driven vectors.
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg, i);
            drain(12);
        end

        // Back-to-back: the second start is driven in the done cycle.
        issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 100);
        for (int i = 0; (i < 10) && (sb.size() != 0); i++) tick();
        issue(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 101);
        check32("result_held", 101, result, 32'h40400000);
        drain(12);

        // Starts while busy are ignored and must not disturb the in-flight op.
        d0 = dones_seen;
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 102);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            op_a  = $urandom;
            op_b  = $urandom;
            op    = 1'($urandom_range(1));
            tick();
        end
        start = 1'b0;
        drain(12);
        repeat (8) tick();
        check32("single_done", 102, dones_seen - d0, 32'd1);

        // Reset mid-operation.
        issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 103);
        tick();
        #2 rst = 1'b1;
        #1;
        sb.delete();
        check32("abort_busy", 103, {31'd0, busy}, 32'd0);
        check32("abort_done", 103, {31'd0, done}, 32'd0);
        check32("abort_result", 103, result, 32'h00000000);
        check32("abort_flags", 103, {28'd0, flags}, 32'd0);
        d0 = dones_seen;
        tick();
        tick();
        rst = 1'b0;
        repeat (8) tick();
        check32("abort_no_done", 103, dones_seen - d0, 32'd0);

        // Recovery after the aborted op.
        issue(32'hC0400000, 32'h3F800000, 1'b0, 32'hC0000000, 4'b0000, 104);
        drain(12);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
